// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings and grant helper for mem_arbiter
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam int DEF_TIMEOUT = 255;

  // On a tie the side that did not win last time goes next.
  function automatic logic pick_grant(input logic req_i, input logic req_d, input logic last);
    if (req_i && req_d) begin
      return (last == GRANT_I) ? GRANT_D : GRANT_I;
    end
    if (req_d) begin
      return GRANT_D;
    end
    return GRANT_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_ibuf.sv
// rtl/mem_arbiter_ibuf.sv - one-entry fetch buffer used when ARB_IBUF_EN is defined
module arb_ibuf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-3:0] i_lookup_tag,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_fill,
  input  logic [ADDR_W-3:0] i_fill_tag,
  input  logic [DATA_W-1:0] i_fill_data,
  input  logic              i_drop,
  input  logic              i_inval,
  input  logic [ADDR_W-3:0] i_inval_tag
);

  logic              r_valid;
  logic [ADDR_W-3:0] r_tag;
  logic [DATA_W-1:0] r_data;

  assign o_hit  = r_valid && (r_tag == i_lookup_tag);
  assign o_data = r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else begin
      if (i_fill) begin
        r_valid <= 1'b1;
        r_tag   <= i_fill_tag;
        r_data  <= i_fill_data;
      end else if (i_drop) begin
        r_valid <= 1'b0;
      end
      // A store to the buffered word makes the copy stale.
      if (i_inval && (r_tag == i_inval_tag)) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port memory between fetch (I) and data (D) sides
// Define ARB_IBUF_EN to add a one-entry fetch buffer in front of the memory path.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              d_err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_wstrb,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);

  logic [1:0]        r_state;
  logic              r_last_grant;
  logic              r_grant;
  logic [TW-1:0]     r_timer;
  logic              r_m_req;
  logic              r_m_we;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata;
  logic [3:0]        r_m_wstrb;
  logic              r_i_ready;
  logic              r_d_ready;
  logic              r_err;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic              w_any_req;
  logic              w_side;
  logic              w_acked;
  logic              w_expired;
  logic              w_store_grant;
  logic              w_ibuf_hit;
  logic [DATA_W-1:0] w_ibuf_data;
  logic              w_unused;

  assign w_any_req     = i_req | d_req;
  assign w_side        = pick_grant(i_req, d_req, r_last_grant);
  assign w_acked       = (r_state == ST_WAIT) && m_ack;
  assign w_expired     = (r_state == ST_WAIT) && !m_ack && (r_timer == TIMER_MAX);
  assign w_store_grant = (r_state == ST_IDLE) && w_any_req && (w_side == GRANT_D) && d_we;
  assign w_unused      = &{1'b0, i_addr[1:0], d_addr[1:0]};

`ifdef ARB_IBUF_EN
  arb_ibuf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ibuf (
    .clk          (clk),
    .rst          (rst),
    .i_lookup_tag (i_addr[ADDR_W-1:2]),
    .o_hit        (w_ibuf_hit),
    .o_data       (w_ibuf_data),
    .i_fill       (w_acked && (r_grant == GRANT_I)),
    .i_fill_tag   (r_m_addr[ADDR_W-1:2]),
    .i_fill_data  (m_rdata),
    .i_drop       (w_expired && (r_grant == GRANT_I)),
    .i_inval      (w_store_grant),
    .i_inval_tag  (d_addr[ADDR_W-1:2])
  );
`else
  assign w_ibuf_hit  = 1'b0;
  assign w_ibuf_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= GRANT_I;
      r_grant      <= GRANT_I;
      r_timer      <= '0;
      r_m_req      <= 1'b0;
      r_m_we       <= 1'b0;
      r_m_addr     <= '0;
      r_m_wdata    <= '0;
      r_m_wstrb    <= 4'b0000;
      r_i_ready    <= 1'b0;
      r_d_ready    <= 1'b0;
      r_err        <= 1'b0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
    end else begin
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_last_grant <= w_side;
            r_grant      <= w_side;
            r_timer      <= '0;
            if ((w_side == GRANT_I) && w_ibuf_hit) begin
              r_state   <= ST_RESP;
              r_i_ready <= 1'b1;
              r_i_rdata <= w_ibuf_data;
            end else begin
              r_state <= ST_WAIT;
              r_m_req <= 1'b1;
              if (w_side == GRANT_D) begin
                r_m_addr  <= {d_addr[ADDR_W-1:2], 2'b00};
                r_m_we    <= d_we;
                r_m_wdata <= d_we ? d_wdata : '0;
                r_m_wstrb <= d_we ? d_wstrb : 4'b0000;
              end else begin
                r_m_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
                r_m_we    <= 1'b0;
                r_m_wdata <= '0;
                r_m_wstrb <= 4'b0000;
              end
            end
          end
        end
        ST_WAIT: begin
          if (m_ack || (r_timer == TIMER_MAX)) begin
            r_state <= ST_RESP;
            r_m_req <= 1'b0;
            r_m_we  <= 1'b0;
            r_err   <= !m_ack;
            if (r_grant == GRANT_D) begin
              r_d_ready <= 1'b1;
              r_d_rdata <= m_ack ? m_rdata : '0;
            end else begin
              r_i_ready <= 1'b1;
              r_i_rdata <= m_ack ? m_rdata : '0;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        // Single ready cycle; requests still high here are not granted again.
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_m_req <= 1'b0;
        end
      endcase
    end
  end

  assign m_req   = r_m_req;
  assign m_we    = r_m_we;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign m_wstrb = r_m_wstrb;
  assign i_ready = r_i_ready;
  assign i_rdata = r_i_rdata;
  assign d_ready = r_d_ready;
  assign d_rdata = r_d_rdata;
  assign d_err   = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (vector table, corner sequences, random vs model)
module tb_mem_arbiter;

  localparam int TO = 4;
  localparam int WAIT_LIMIT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        d_err;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        m_ack;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:63];

  bit resp_off = 1'b0;
  int forced_delay = -1;
  bit rs_busy = 1'b0;
  bit rs_abandon = 1'b0;
  int rs_cnt = 0;
  bit abandon_seen = 1'b0;

  typedef struct {
    bit          side;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          delay;
    bit          chk_rd;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
    int          exp_mreq;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_mwstrb;
  } vec_t;

  vec_t vecs [0:7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    end
    return r;
  endfunction

  // Memory: answers after a chosen number of WAIT cycles, or never (abandon).
  task automatic respond();
    if (!resp_off) begin
      m_ack = 1'b0;
      m_rdata = '0;
      if (m_req) begin
        if (!rs_busy) begin
          rs_busy = 1'b1;
          if (forced_delay >= 0) rs_cnt = forced_delay;
          else rs_cnt = ($urandom_range(0, 11) == 0) ? 99 : int'($urandom_range(0, 3));
          rs_abandon = (rs_cnt > TO);
          if (rs_abandon) abandon_seen = 1'b1;
        end
        if (!rs_abandon) begin
          if (rs_cnt == 0) begin
            m_ack = 1'b1;
            m_rdata = mem[m_addr[7:2]];
            if (m_we) mem[m_addr[7:2]] = merge(mem[m_addr[7:2]], m_wdata, m_wstrb);
            rs_cnt = -1;
          end else if (rs_cnt > 0) begin
            rs_cnt--;
          end
        end
      end else begin
        rs_busy = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    respond();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_txn(input bit side, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int delay,
                         output int lat, output logic [31:0] rdata, output logic err, output int mreq_n,
                         output logic mwe, output logic [3:0] mwstrb, output logic [31:0] mwdata,
                         output logic [31:0] maddr);
    bit done;
    bit seen;
    forced_delay = delay;
    lat = 0; mreq_n = 0; rdata = '0; err = 1'b0;
    mwe = 1'b0; mwstrb = '0; mwdata = '0; maddr = '0;
    done = 1'b0; seen = 1'b0;
    if (side) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_wstrb = wstrb;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    while (!done && lat < 40) begin
      tick();
      lat++;
      if (m_req) begin
        mreq_n++;
        if (!seen) begin
          seen = 1'b1; mwe = m_we; mwstrb = m_wstrb; mwdata = m_wdata; maddr = m_addr;
        end
      end
      if (side ? d_ready : i_ready) begin
        done = 1'b1;
        rdata = side ? d_rdata : i_rdata;
        err = d_err;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    forced_delay = -1;
    tick();
  endtask

  initial begin
    int lat, mreq_n, n;
    logic [31:0] rdata, mwdata, maddr;
    logic [3:0] mwstrb;
    logic err, mwe;
    bit got[$];
    bit i_pend, d_pend;
    int i_wait, d_wait, i_others, d_others, max_i, max_d;

    for (int k = 0; k < 64; k++) mem[k] = '0;
    mem[4] = 32'hDEADBEEF;
    mem[8] = 32'h55AA55AA;
    m_ack = 1'b0;
    m_rdata = '0;

    vecs[0] = '{1'b1, 1'b0, 32'h10, 32'h0,        4'hF,    0,  1'b1, 32'hDEADBEEF, 1'b0, 2, 1, 32'h10, 4'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h12, 32'h12345678, 4'b0011, 1,  1'b0, 32'h0,        1'b0, 3, 2, 32'h10, 4'b0011};
    vecs[2] = '{1'b1, 1'b0, 32'h10, 32'h0,        4'hF,    2,  1'b1, 32'hDEAD5678, 1'b0, 4, 3, 32'h10, 4'h0};
    vecs[3] = '{1'b0, 1'b0, 32'h13, 32'h0,        4'h0,    0,  1'b1, 32'hDEAD5678, 1'b0, 2, 1, 32'h10, 4'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h20, 32'h0,        4'h0,    99, 1'b1, 32'h0,        1'b1, 6, 5, 32'h20, 4'h0};
    vecs[5] = '{1'b1, 1'b1, 32'h24, 32'hAABBCCDD, 4'b1100, 4,  1'b0, 32'h0,        1'b0, 6, 5, 32'h24, 4'b1100};
    vecs[6] = '{1'b0, 1'b0, 32'h24, 32'h0,        4'h0,    3,  1'b1, 32'hAABB0000, 1'b0, 5, 4, 32'h24, 4'h0};
    vecs[7] = '{1'b0, 1'b0, 32'h20, 32'h0,        4'h0,    99, 1'b1, 32'h0,        1'b1, 6, 5, 32'h20, 4'h0};

    do_reset();
    chk("rst_i_ready", 32'(i_ready), 32'h0);
    chk("rst_d_ready", 32'(d_ready), 32'h0);
    chk("rst_d_err", 32'(d_err), 32'h0);
    chk("rst_m_req", 32'(m_req), 32'h0);
    chk("rst_m_we", 32'(m_we), 32'h0);
    chk("rst_m_wstrb", 32'(m_wstrb), 32'h0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_wdata", m_wdata, 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    tick();

    for (int v = 0; v < 8; v++) begin
      run_txn(vecs[v].side, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].wstrb, vecs[v].delay,
              lat, rdata, err, mreq_n, mwe, mwstrb, mwdata, maddr);
      chk($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
      chk($sformatf("vec%0d_mreq_cycles", v), 32'(mreq_n), 32'(vecs[v].exp_mreq));
      chk($sformatf("vec%0d_m_addr", v), maddr, vecs[v].exp_maddr);
      chk($sformatf("vec%0d_m_wstrb", v), 32'(mwstrb), 32'(vecs[v].exp_mwstrb));
      chk($sformatf("vec%0d_m_we", v), 32'(mwe), 32'(vecs[v].we));
      chk($sformatf("vec%0d_err", v), 32'(err), 32'(vecs[v].exp_err));
      if (vecs[v].chk_rd) chk($sformatf("vec%0d_rdata", v), rdata, vecs[v].exp_rdata);
      if (vecs[v].we) chk($sformatf("vec%0d_m_wdata", v), mwdata, vecs[v].wdata);
    end

    // Both sides held from reset: grants must alternate starting with D.
    rst = 1'b1;
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h10; d_addr = 32'h20; d_we = 1'b0;
    forced_delay = 0;
    tick();
    tick();
    rst = 1'b0;
    n = 0;
    while (got.size() < 4 && n < 60) begin
      tick();
      n++;
      if (i_ready && d_ready) chk("contention_exclusive", 32'h1, 32'h0);
      if (d_ready) got.push_back(1'b1);
      if (i_ready) got.push_back(1'b0);
    end
    chk("contention_count", 32'(got.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < got.size()) chk($sformatf("contention_order%0d", k), 32'(got[k]), 32'((k % 2) == 0));
    end
    forced_delay = -1;
    do_reset();

    // Reset while WAIT, then a late ack: nothing may respond to it.
    resp_off = 1'b1;
    m_ack = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
    n = 0;
    while (!m_req && n < 10) begin
      tick();
      n++;
    end
    chk("rstwait_mreq_up", 32'(m_req), 32'h1);
    tick();
    rst = 1'b1;
    d_req = 1'b0;
    tick();
    chk("rstwait_mreq_drop", 32'(m_req), 32'h0);
    rst = 1'b0;
    m_ack = 1'b1;
    m_rdata = 32'hFFFFFFFF;
    tick();
    chk("rstwait_no_dready", 32'(d_ready), 32'h0);
    chk("rstwait_no_iready", 32'(i_ready), 32'h0);
    chk("rstwait_m_addr", m_addr, 32'h0);
    m_ack = 1'b0;
    tick();
    chk("rstwait_late_dready", 32'(d_ready), 32'h0);
    chk("rstwait_d_rdata", d_rdata, 32'h0);
    chk("rstwait_m_req", 32'(m_req), 32'h0);
    resp_off = 1'b0;
    rs_busy = 1'b0;
    m_rdata = '0;

`ifdef ARB_IBUF_EN
    do_reset();
    mem[0] = 32'hCAFEF00D;
    run_txn(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 0, lat, rdata, err, mreq_n, mwe, mwstrb, mwdata, maddr);
    chk("ibuf_first_latency", 32'(lat), 32'd2);
    chk("ibuf_first_rdata", rdata, 32'hCAFEF00D);
    run_txn(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 0, lat, rdata, err, mreq_n, mwe, mwstrb, mwdata, maddr);
    chk("ibuf_hit_latency", 32'(lat), 32'd1);
    chk("ibuf_hit_no_mreq", 32'(mreq_n), 32'd0);
    chk("ibuf_hit_rdata", rdata, 32'hCAFEF00D);
    run_txn(1'b1, 1'b1, 32'h100, 32'h11111111, 4'hF, 0, lat, rdata, err, mreq_n, mwe, mwstrb, mwdata, maddr);
    run_txn(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 0, lat, rdata, err, mreq_n, mwe, mwstrb, mwdata, maddr);
    chk("ibuf_inval_mreq", 32'(mreq_n), 32'd1);
    chk("ibuf_inval_latency", 32'(lat), 32'd2);
    chk("ibuf_inval_rdata", rdata, 32'h11111111);
`endif

    // Random traffic against a word-level memory model.
    do_reset();
    for (int k = 0; k < 64; k++) ref_mem[k] = mem[k];
    abandon_seen = 1'b0;
    i_pend = 1'b0; d_pend = 1'b0;
    i_wait = 0; d_wait = 0; i_others = 0; d_others = 0; max_i = 0; max_d = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (i_pend) i_wait++;
      if (d_pend) d_wait++;
      if (i_ready || d_ready) chk("rand_ready_exclusive", 32'(i_ready && d_ready), 32'h0);
      if (i_ready) begin
        chk("rand_i_err", 32'(d_err), 32'(abandon_seen));
        chk("rand_i_rdata", i_rdata, abandon_seen ? 32'h0 : ref_mem[i_addr[7:2]]);
        chk("rand_i_fair", 32'(i_others <= 1), 32'h1);
        abandon_seen = 1'b0;
        if (i_wait > max_i) max_i = i_wait;
        i_pend = 1'b0; i_req = 1'b0;
        if (d_pend) d_others++;
      end
      if (d_ready) begin
        chk("rand_d_err", 32'(d_err), 32'(abandon_seen));
        if (!d_we) chk("rand_d_rdata", d_rdata, abandon_seen ? 32'h0 : ref_mem[d_addr[7:2]]);
        else if (!abandon_seen) ref_mem[d_addr[7:2]] = merge(ref_mem[d_addr[7:2]], d_wdata, d_wstrb);
        chk("rand_d_fair", 32'(d_others <= 1), 32'h1);
        abandon_seen = 1'b0;
        if (d_wait > max_d) max_d = d_wait;
        d_pend = 1'b0; d_req = 1'b0;
        if (i_pend) i_others++;
      end
      if (cyc < 2900) begin
        if (!i_pend && $urandom_range(0, 2) == 0) begin
          i_pend = 1'b1; i_req = 1'b1; i_wait = 0; i_others = 0;
          i_addr = ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
        end
        if (!d_pend && $urandom_range(0, 2) == 0) begin
          d_pend = 1'b1; d_req = 1'b1; d_wait = 0; d_others = 0;
          d_we = $urandom_range(0, 1) == 1;
          d_addr = ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
          d_wdata = $urandom;
          d_wstrb = 4'($urandom_range(0, 15));
        end
      end
    end
    chk("rand_drained", 32'(i_pend || d_pend), 32'h0);
    chk("rand_max_wait_i", 32'(max_i <= WAIT_LIMIT), 32'h1);
    chk("rand_max_wait_d", 32'(max_d <= WAIT_LIMIT), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
